// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control sequencer for the 10-bit datapath.
// Captures an instruction on EXEC in T0, then walks T1..T3 driving the
// register-file, ALU-latch, ALU-function and bus-select controls.
// All state and outputs update on the falling edge of CLKb; CLRb is an
// asynchronous active-low clear.
module cpu_control_fsm #(
  localparam int DW = 10
) (
  input  logic          CLKb,
  input  logic          CLRb,
  input  logic          EXEC,
  input  logic [DW-1:0] INSTR,
  output logic          ENW,
  output logic [1:0]    WRA,
  output logic          ENR0,
  output logic [1:0]    RDA0,
  output logic          ENR1,
  output logic [1:0]    RDA1,
  output logic [1:0]    BusSel,
  output logic          LdA,
  output logic          LdG,
  output logic [3:0]    ALUcont,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  typedef struct packed {
    logic       enw;
    logic [1:0] wra;
    logic       enr0;
    logic [1:0] rda0;
    logic       enr1;
    logic [1:0] rda1;
    logic [1:0] bussel;
    logic       lda;
    logic       ldg;
    logic [3:0] aluc;
    logic       busy;
    logic       done;
  } ctl_t;

  state_t        state, nstate;
  logic [DW-1:0] ir, nir;
  ctl_t          ctl;

  // Opcodes 0010..1000 go through the ALU path (T1 -> T2 -> T3).
  function automatic logic is_alu(input logic [3:0] opc);
    return (opc >= 4'd2) && (opc <= 4'd8);
  endfunction

  // ALU ops that read a second operand from Ry.
  function automatic logic is_two_op(input logic [3:0] opc);
    return (opc == 4'd2) || (opc == 4'd3) || (opc == 4'd6) ||
           (opc == 4'd7) || (opc == 4'd8);
  endfunction

  // Moore control word for a given state and instruction.
  function automatic ctl_t decode(input state_t st, input logic [3:0] opc,
                                  input logic [1:0] rx, input logic [1:0] ry);
    ctl_t c;
    c = '0;
    case (st)
      T1: begin
        c.busy = 1'b1;
        if (opc == 4'd0) begin
          c.bussel = 2'b01;
          c.enw    = 1'b1;
          c.wra    = rx;
          c.done   = 1'b1;
        end else if (opc == 4'd1) begin
          c.enr0   = 1'b1;
          c.rda0   = ry;
          c.bussel = 2'b10;
          c.enw    = 1'b1;
          c.wra    = rx;
          c.done   = 1'b1;
        end else if (is_alu(opc)) begin
          c.enr0   = 1'b1;
          c.rda0   = rx;
          c.bussel = 2'b10;
          c.lda    = 1'b1;
        end else begin
          c.done   = 1'b1;
        end
      end
      T2: begin
        c.busy = 1'b1;
        c.aluc = opc;
        c.ldg  = 1'b1;
        if (is_two_op(opc)) begin
          c.enr1 = 1'b1;
          c.rda1 = ry;
        end
      end
      T3: begin
        c.busy   = 1'b1;
        c.bussel = 2'b11;
        c.enw    = 1'b1;
        c.wra    = rx;
        c.done   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state and next IR; IR only reloads on the edge leaving T0 with EXEC.
  always_comb begin
    nstate = state;
    nir    = ir;
    case (state)
      T0: begin
        if (EXEC) begin
          nstate = T1;
          nir    = INSTR;
        end
      end
      T1:      nstate = is_alu(ir[9:6]) ? T2 : T0;
      T2:      nstate = T3;
      T3:      nstate = T0;
      default: nstate = T0;
    endcase
  end

  // State, IR and registered outputs; outputs are decoded from the next
  // state/IR so they are valid for the whole cycle of the state they describe.
  always_ff @(negedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      state <= T0;
      ir    <= '0;
      ctl   <= '0;
    end else begin
      state <= nstate;
      ir    <= nir;
      ctl   <= decode(nstate, nir[9:6], nir[5:4], nir[3:2]);
    end
  end

  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[1:0];

  assign ENW     = ctl.enw;
  assign WRA     = ctl.wra;
  assign ENR0    = ctl.enr0;
  assign RDA0    = ctl.rda0;
  assign ENR1    = ctl.enr1;
  assign RDA1    = ctl.rda1;
  assign BusSel  = ctl.bussel;
  assign LdA     = ctl.lda;
  assign LdG     = ctl.ldg;
  assign ALUcont = ctl.aluc;
  assign Busy    = ctl.busy;
  assign Done    = ctl.done;

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the 10-bit datapath. It captures one instruction word on a start request and steps it through states T0–T3. From each state it drives the register-file controls (ENW, WRA, ENR0/RDA0, ENR1/RDA1), the ALU operand and result latches, the ALU function select and the shared data-bus source select. It sits directly upstream of the 4×10-bit register file and the ALU, and consumes the instruction word.

## Interface
Parameters:
- DW, 10, datapath and instruction width; fixed, not overridable.

Ports:
- CLKb  in  1  clock; all state updates on the falling edge of CLKb.
- CLRb  in  1  reset, asynchronous, active-low.
- EXEC  in  1  start request, level-sampled in T0 only.
- INSTR  in  10  instruction word.
  - [9:6] opcode, [5:4] Rx (destination / first operand), [3:2] Ry (second operand), [1:0] unused.
- ENW  out  1  register-file write enable.
- WRA  out  2  register-file write address.
- ENR0  out  1  read-port-0 enable.
- RDA0  out  2  read-port-0 address.
- ENR1  out  1  read-port-1 enable.
- RDA1  out  2  read-port-1 address.
- BusSel  out  2  bus source: 00 none, 01 external DIN, 10 register-file Q0, 11 ALU result register G.
- LdA  out  1  latch the bus into ALU operand register A.
- LdG  out  1  latch the ALU output into G.
- ALUcont  out  4  ALU function; equals the captured opcode in T2, 0000 otherwise.
- Busy  out  1  high in T1–T3.
- Done  out  1  one-cycle pulse in the final state of each instruction.

## Operation
- Internal IR (10 bits) captures INSTR on the falling edge that leaves T0 with EXEC=1. The IR holds until the next capture.
- Opcodes:
  - 0000 LOAD: Rx←DIN.
  - 0001 COPY: Rx←Ry.
  - 0010 ADD: Rx←Rx+Ry.
  - 0011 SUB: Rx←Rx−Ry.
  - 0100 INV: Rx←~Rx.
  - 0101 FLP: Rx←−Rx.
  - 0110 AND, 0111 OR, 1000 XOR: Rx←Rx op Ry.
  - 1001–1111: reserved, executed as NOP.
- Outputs are Moore, decoded from the state and IR only. Every output not listed for a state is 0.
- T0 (idle): Busy=0. If EXEC=1, capture the IR and go to T1; otherwise stay in T0.
- T1:
  - LOAD: BusSel=01, ENW=1, WRA=Rx, Done=1; next state T0.
  - COPY: ENR0=1, RDA0=Ry, BusSel=10, ENW=1, WRA=Rx, Done=1; next state T0.
  - NOP: Done=1; next state T0.
  - ALU ops (0010–1000): ENR0=1, RDA0=Rx, BusSel=10, LdA=1; next state T2.
- T2 (ALU ops only):
  - ALUcont=opcode, LdG=1.
  - Two-operand ops (ADD, SUB, AND, OR, XOR): ENR1=1, RDA1=Ry.
  - INV and FLP: ENR1=0, RDA1=00.
  - Next state T3.
- T3: BusSel=11, ENW=1, WRA=Rx, Done=1; next state T0.
- ENW is high in exactly one state per LOAD, COPY or ALU instruction, and never for NOP.
- Rx=Ry is legal; the read precedes the write, so ADD R1,R1 doubles R1.
- Arithmetic wraps modulo 2^10 inside the ALU; this block generates no flags.
- EXEC in T1–T3 is ignored; no queuing.
- If EXEC is held high, the next instruction is captured on the edge leaving the T0 that follows Done. There is therefore always at least one T0 cycle between instructions.

## Timing
- Reset: CLRb=0 immediately forces state T0, IR=0 and all outputs 0, including mid-instruction. The register-file write in progress is aborted: ENW drops asynchronously.
- The first capture can occur on the first falling edge with CLRb=1 and EXEC=1.
- Latency from the capture edge to Done:
  - LOAD / COPY / NOP: 1 cycle (Done in T1).
  - ALU ops: 3 cycles (Done in T3).
- Throughput with EXEC held high: 2 cycles per LOAD/COPY/NOP, 4 cycles per ALU op.
- Controls are stable for a full CLKb period. The register file and the A/G latches sample them on the next falling edge, i.e. the edge that leaves the state.
- Busy rises on the capture edge and falls on the edge leaving the final state. Done is coincident with the last Busy cycle.

## Test plan
- Reset, then EXEC=1 with INSTR=0000_01_00_00 (LOAD R1) → next cycle: BusSel=01, ENW=1, WRA=01, Done=1; the following cycle T0 with all outputs 0.
- INSTR=0010_10_11_00 (ADD R2,R3) → T1: ENR0=1, RDA0=10, LdA=1 → T2: ENR1=1, RDA1=11, ALUcont=0010, LdG=1 → T3: BusSel=11, ENW=1, WRA=10, Done=1.
- INSTR=0100_00_xx_00 (INV R0) → T2: ENR1=0, ALUcont=0100; T3 writes WRA=00.
- INSTR=1010_xx_xx_xx (reserved) → 1-cycle Done, ENW never asserted.
- EXEC toggled in T1–T3 of a SUB → ignored; IR unchanged.
  - EXEC held high through Done → the next instruction is captured after exactly one T0 cycle.
- CLRb pulsed low during T2 of an ADD → all outputs 0 asynchronously; ENW never asserted for that instruction; a fresh EXEC after release starts normally.
